spi_memory_param: RTL and testbench

- Parametrised SPI slave memory, the next generation of the lab SPI memory block.
- Configurable address width, data width and depth.
- Conditions the raw SPI pins into the system clock domain and runs a one-hot frame FSM over an internal RAM.
- Supports single-word or burst (auto-increment) read/write frames.
- Sits between the board SPI pins and the lab FPGA fabric; it is the only consumer of sclk_pin/cs_pin/mosi_pin.

---
 rtl/spi_memory_pkg.sv | 21 ++
 rtl/spi_input_conditioner.sv | 38 +++
 rtl/spi_memory_param.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_memory_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_memory_pkg.sv
// Shared types and constants for the parametrised SPI slave memory.
package spi_memory_pkg;

  typedef logic [4:0] state_t;

  localparam int unsigned IDLE_B  = 0;
  localparam int unsigned ADDR_B  = 1;
  localparam int unsigned WRITE_B = 2;
  localparam int unsigned READ_B  = 3;
  localparam int unsigned DONE_B  = 4;

  localparam state_t IDLE  = 5'b00001;
  localparam state_t ADDR  = 5'b00010;
  localparam state_t WRITE = 5'b00100;
  localparam state_t READ  = 5'b01000;
  localparam state_t DONE  = 5'b10000;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_input_conditioner.sv
// Synchronises one raw SPI pin into the clk domain and produces registered edge pulses.
module spi_input_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  // Pulses are registered so pin-to-pulse latency is SYNC_STAGES+1 clk; level aligns with them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_memory_param.sv
// Parametrised SPI slave memory (mode 0, MSB-first) with a one-hot frame FSM over internal RAM.
// Define SPI_MEMORY_BURST_EN for auto-increment burst frames; otherwise one word per frame.
module spi_memory_param
  import spi_memory_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk_pin,
  input  logic cs_pin,
  input  logic mosi_pin,
  output logic miso_pin,
  output logic miso_oe,
  output logic busy
);

`ifdef SPI_MEMORY_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  logic sclk_rise, sclk_fall, sclk_lvl;
  logic cs_rise, cs_fall, cs_lvl;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sclk_cond (
    .clk    (clk),
    .reset_n(reset_n),
    .pin    (sclk_pin),
    .level  (sclk_lvl),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  // cs idles high, so its synchroniser resets high to avoid a spurious edge after reset.
  spi_input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_cs_cond (
    .clk    (clk),
    .reset_n(reset_n),
    .pin    (cs_pin),
    .level  (cs_lvl),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_mosi_cond (
    .clk    (clk),
    .reset_n(reset_n),
    .pin    (mosi_pin),
    .level  (mosi_lvl),
    .rise   (mosi_rise),
    .fall   (mosi_fall)
  );

  assign unused_edges = ^{sclk_lvl, cs_fall, mosi_rise, mosi_fall};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   next_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_word;
  logic                addr_in_range;

  assign addr_in_range = 32'(addr_q) < DEPTH;
  assign next_addr     = (32'(addr_q) >= DEPTH - 1) ? '0 : addr_q + ADDR_W'(1);
  // In READ the only lookup needed is the burst preload of the following word.
  assign rd_addr       = state_q[READ_B] ? next_addr : addr_q;
  assign rd_word       = (32'(rd_addr) < DEPTH) ? mem[rd_addr[IDX_W-1:0]] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      mem[wr_addr_q] <= wr_data_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // cs rise has priority over any coincident sclk edge; a partial word is simply dropped.
    if (cs_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sclk_rise && !cs_lvl) begin
            addr_d  = {addr_q[ADDR_W-2:0], mosi_lvl};
            cnt_d   = CNT_W'(1);
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            if (cnt_q != CNT_W'(ADDR_W)) begin
              addr_d = {addr_q[ADDR_W-2:0], mosi_lvl};
              cnt_d  = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = '0;
              if (mosi_lvl == RW_READ) begin
                tx_d    = rd_word;
                state_d = READ;
              end else begin
                state_d = WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (sclk_rise) begin
            rx_d = {rx_q[DATA_W-2:0], mosi_lvl};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d     = '0;
              wr_en_d   = addr_in_range;
              wr_addr_d = addr_q[IDX_W-1:0];
              wr_data_d = {rx_q[DATA_W-2:0], mosi_lvl};
              if (BURST_EN) begin
                addr_d = next_addr;
              end else begin
                state_d = DONE;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        READ: begin
          if (sclk_fall) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d = '0;
              if (BURST_EN) begin
                addr_d = next_addr;
                tx_d   = rd_word;
              end else begin
                state_d = DONE;
                miso_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy     = ~state_q[IDLE_B];
    miso_oe  = state_q[READ_B];
    miso_pin = state_q[READ_B] & miso_q;
  end

endmodule

// File: tb/tb_spi_memory_param.sv
// Directed self-checking bench for spi_memory_param (default DEPTH plus a DEPTH=100 instance).
module tb_spi_memory_param;

  localparam int HALF = 8;

`ifdef SPI_MEMORY_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sclk    = 1'b0;
  logic cs      = 1'b1;
  logic mosi    = 1'b0;
  logic miso, miso_oe, busy;
  logic miso100, oe100, busy100;

  int checks = 0;
  int errors = 0;

  logic       smp_miso, smp_oe, smp_miso100;
  logic [7:0] w, w100, w2, w2_100, exp0;
  int         oe_low, oe_low2, n;

  always #5 clk = ~clk;

  spi_memory_param #(
    .ADDR_W     (7),
    .DATA_W     (8),
    .DEPTH      (128),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sclk_pin(sclk),
    .cs_pin  (cs),
    .mosi_pin(mosi),
    .miso_pin(miso),
    .miso_oe (miso_oe),
    .busy    (busy)
  );

  spi_memory_param #(
    .ADDR_W     (7),
    .DATA_W     (8),
    .DEPTH      (100),
    .SYNC_STAGES(2)
  ) dut100 (
    .clk     (clk),
    .reset_n (reset_n),
    .sclk_pin(sclk),
    .cs_pin  (cs),
    .mosi_pin(mosi),
    .miso_pin(miso100),
    .miso_oe (oe100),
    .busy    (busy100)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // One mode-0 bit: drive mosi, sample miso just before the rising edge, then fall.
  task automatic sbit(input logic b);
    mosi = b;
    repeat (HALF) @(negedge clk);
    smp_miso    = miso;
    smp_oe      = miso_oe;
    smp_miso100 = miso100;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) sbit(v[i]);
  endtask

  task automatic get_word(output logic [7:0] rw, output logic [7:0] rw100, output int oe_bad);
    oe_bad = 0;
    for (int i = 7; i >= 0; i--) begin
      sbit(1'b0);
      rw[i]   = smp_miso;
      rw100[i] = smp_miso100;
      if (smp_oe !== 1'b1) oe_bad++;
    end
  endtask

  task automatic start_frame();
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic write_word(input logic [6:0] a, input logic [7:0] d);
    start_frame();
    send(32'(a), 7);
    sbit(1'b0);
    send(32'(d), 8);
    end_frame();
  endtask

  task automatic read_word(input logic [6:0] a, output logic [7:0] rw, output logic [7:0] rw100,
                           output int oe_bad);
    start_frame();
    send(32'(a), 7);
    sbit(1'b1);
    get_word(rw, rw100, oe_bad);
    end_frame();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 0);
    check("rst_oe", 32'(miso_oe), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xAA to address 0 and time the busy release.
    start_frame();
    send(32'h00, 7);
    check("busy_in_frame", 32'(busy), 1);
    sbit(1'b0);
    send(32'hAA, 8);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    n  = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_lat", 32'(n <= 4 && busy === 1'b0), 1);
    repeat (2 * HALF) @(negedge clk);

    // Read address 0, then clock extra bits while in DONE.
    start_frame();
    send(32'h00, 7);
    sbit(1'b1);
    check("rw_bit_oe", 32'(smp_oe), 0);
    get_word(w, w100, oe_low);
    check("rd_addr0", 32'(w), 32'hAA);
    check("rd_oe_bits", 32'(oe_low), 0);
    send(32'h7, 3);
    check("done_miso", 32'(smp_miso), 0);
    check("done_oe", 32'(smp_oe), 0);
    check("done_busy", 32'(busy), 1);
    end_frame();

    // Aborted write must not commit.
    write_word(7'h55, 8'hC3);
    start_frame();
    send(32'h55, 7);
    sbit(1'b0);
    send(32'h07, 5);
    end_frame();
    read_word(7'h55, w, w100, oe_low);
    check("abort_keep", 32'(w), 32'hC3);
    write_word(7'h55, 8'h3C);
    read_word(7'h55, w, w100, oe_low);
    check("full_write", 32'(w), 32'h3C);

    // Two words in one frame starting at the last address.
    start_frame();
    send(32'h7F, 7);
    sbit(1'b0);
    send(32'h11, 8);
    send(32'h22, 8);
    end_frame();
    read_word(7'h7F, w, w100, oe_low);
    check("burst_wr_7f", 32'(w), 32'h11);
    exp0 = BURST ? 8'h22 : 8'hAA;
    read_word(7'h00, w, w100, oe_low);
    check("burst_wr_00", 32'(w), 32'(exp0));
    start_frame();
    send(32'h7F, 7);
    sbit(1'b1);
    get_word(w, w100, oe_low);
    get_word(w2, w2_100, oe_low2);
    end_frame();
    check("burst_rd_w0", 32'(w), 32'h11);
    check("burst_rd_w1", 32'(w2), BURST ? 32'h22 : 32'h00);
    check("burst_rd_oe1", 32'(oe_low2), BURST ? 0 : 8);

    // Reset mid-read after three data bits (bit 5 of exp0 is on miso).
    start_frame();
    send(32'h00, 7);
    sbit(1'b1);
    send(32'h0, 3);
    check("pre_rst_miso", 32'(miso), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_miso", 32'(miso), 0);
    check("mid_rst_oe", 32'(miso_oe), 0);
    check("mid_rst_busy", 32'(busy), 0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    read_word(7'h00, w, w100, oe_low);
    check("post_rst_rd", 32'(w), 32'(exp0));

    // Address 0x70 is valid for DEPTH=128 but out of range for DEPTH=100.
    write_word(7'h70, 8'h5A);
    read_word(7'h70, w, w100, oe_low);
    check("rd_70_d128", 32'(w), 32'h5A);
    check("rd_70_d100", 32'(w100), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
